// File: rtl/cp0_regfile.sv
// Purpose : MIPS CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) beside MEM/WB.
// Latency : reads/flush/new_pc/int_req combinational from registered state; writes take effect next edge.
// Backpressure: none; exception > ERET > MTC0 arbitrated in one cycle, lower-priority event dropped.
//
// Optional timer: define CP0_TIMER_EN to build Count/Compare and the timer interrupt.
// Without it, registers 9/11 read 0, writes to them are ignored, and TI is constant 0.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mtc0_we/mtc0_addr/mtc0_wdata      MTC0 write from MEM
//   mfc0_addr/mfc0_rdata              MFC0 combinational read (0 for unimplemented numbers)
//   ex_valid/ex_code/ex_bd/ex_pc/ex_badvaddr   committed exception
//   eret                              committed ERET
//   hw_int                            level-sensitive external interrupt lines
//   int_req, flush, new_pc, status_exl   to pipeline control
module cp0_regfile #(
    parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mtc0_we,
    input  logic [4:0]            mtc0_addr,
    input  logic [31:0]           mtc0_wdata,
    input  logic [4:0]            mfc0_addr,
    output logic [31:0]           mfc0_rdata,
    input  logic                  ex_valid,
    input  logic [4:0]            ex_code,
    input  logic                  ex_bd,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_badvaddr,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  int_req,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  status_exl
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Architectural state
    logic [31:0]           r_badvaddr;
    logic [31:0]           r_epc;
    logic [7:0]            r_im;
    logic                  r_exl;
    logic                  r_ie;
    logic                  r_bd;
    logic [4:0]            r_exccode;
    logic [1:0]            r_ip_sw;
    logic [HW_INT_NUM-1:0] r_ip_hw;

    // Timer view (constant 0 when the timer is not built)
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;

    logic        w_mtc0_acc;
    logic        w_eret_acc;
    logic [5:0]  w_hw6;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    // An MTC0 only lands when nothing of higher priority commits in the same cycle.
    assign w_mtc0_acc = mtc0_we & ~ex_valid & ~eret;
    assign w_eret_acc = eret & ~ex_valid;

    // Hardware lines occupy IP[2 +: HW_INT_NUM]; the timer shares IP[7] with the
    // sixth hardware line, so the two are ORed as on classic MIPS cores.
    assign w_hw6 = 6'(r_ip_hw);
    assign w_ip  = {w_hw6[5] | w_ti, w_hw6[4:0], r_ip_sw};

    assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

    assign int_req    = r_ie & ~r_exl & (|(w_ip & r_im));
    assign flush      = ex_valid | eret;
    assign new_pc     = ex_valid ? EXC_VEC : r_epc;
    assign status_exl = r_exl;

    always_comb begin
        mfc0_rdata = 32'h0;
        case (mfc0_addr)
            REG_BADVADDR: mfc0_rdata = r_badvaddr;
            REG_COUNT:    mfc0_rdata = w_count;
            REG_COMPARE:  mfc0_rdata = w_compare;
            REG_STATUS:   mfc0_rdata = w_status;
            REG_CAUSE:    mfc0_rdata = w_cause;
            REG_EPC:      mfc0_rdata = r_epc;
            default:      mfc0_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr <= 32'h0;
            r_epc      <= 32'h0;
            r_im       <= 8'h0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exccode  <= 5'h0;
            r_ip_sw    <= 2'b0;
            r_ip_hw    <= '0;
        end else begin
            r_ip_hw <= hw_int;
            if (ex_valid) begin
                // A nested exception (EXL already set) keeps the original return point.
                if (!r_exl) begin
                    r_epc <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
                    r_bd  <= ex_bd;
                end
                r_exl     <= 1'b1;
                r_exccode <= ex_code;
                if (ex_code == 5'd4 || ex_code == 5'd5) begin
                    r_badvaddr <= ex_badvaddr;
                end
            end else if (w_eret_acc) begin
                r_exl <= 1'b0;
            end else if (w_mtc0_acc) begin
                case (mtc0_addr)
                    REG_STATUS: begin
                        r_im  <= mtc0_wdata[15:8];
                        r_exl <= mtc0_wdata[1];
                        r_ie  <= mtc0_wdata[0];
                    end
                    REG_CAUSE: r_ip_sw <= mtc0_wdata[9:8];
                    REG_EPC:   r_epc   <= mtc0_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [3:0]  r_div;
    logic        r_ti;
    logic        r_cnt_tick;   // Count incremented on the previous edge
    logic        w_div_wrap;

    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_count    = r_count;
    assign w_compare  = r_compare;
    assign w_ti       = r_ti;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 32'h0;
            r_compare  <= 32'h0;
            r_div      <= 4'h0;
            r_ti       <= 1'b0;
            r_cnt_tick <= 1'b0;
        end else begin
            // Match only counts when Count has just advanced, so a stationary
            // Count equal to Compare does not retrigger after software clears TI.
            if (w_mtc0_acc && mtc0_addr == REG_COMPARE) begin
                r_compare <= mtc0_wdata;
                r_ti      <= 1'b0;
            end else if (r_cnt_tick && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end

            if (w_mtc0_acc && mtc0_addr == REG_COUNT) begin
                r_count    <= mtc0_wdata;
                r_div      <= 4'h0;
                r_cnt_tick <= 1'b0;
            end else if (w_div_wrap) begin
                r_count    <= r_count + 32'd1;
                r_div      <= 4'h0;
                r_cnt_tick <= 1'b1;
            end else begin
                r_div      <= r_div + 4'd1;
                r_cnt_tick <= 1'b0;
            end
        end
    end
`else
    assign w_count   = 32'h0;
    assign w_compare = 32'h0;
    assign w_ti      = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam int          COUNT_DIV = 2;

    logic        clk;
    logic        rst;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        ex_valid;
    logic [4:0]  ex_code;
    logic        ex_bd;
    logic [31:0] ex_pc;
    logic [31:0] ex_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic        int_req;
    logic        flush;
    logic [31:0] new_pc;
    logic        status_exl;

    int total = 0;
    int bad   = 0;

    cp0_regfile #(.EXC_VEC(EXC_VEC), .HW_INT_NUM(6), .COUNT_DIV(COUNT_DIV)) dut (
        .clk(clk), .rst(rst),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .ex_valid(ex_valid), .ex_code(ex_code), .ex_bd(ex_bd), .ex_pc(ex_pc),
        .ex_badvaddr(ex_badvaddr), .eret(eret), .hw_int(hw_int),
        .int_req(int_req), .flush(flush), .new_pc(new_pc), .status_exl(status_exl)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: architectural register contents
    logic [31:0] m_bad, m_epc, m_count, m_cmp;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_just;
    logic [4:0]  m_code;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    int          m_div;

    task automatic m_reset();
        m_bad = 0; m_epc = 0; m_count = 0; m_cmp = 0; m_im = 0;
        m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_just = 0;
        m_code = 0; m_sw = 0; m_hw = 0; m_div = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        logic [31:0] v;
        case (a)
            5'd8:  v = m_bad;
            5'd9:  v = m_count;
            5'd11: v = m_cmp;
            5'd12: v = 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13: v = (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
            5'd14: v = m_epc;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic m_irq();
        return m_ie && !m_exl && ((m_ip() & m_im) != 8'h0);
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic m_step();
        logic acc;
        logic hit;
        if (rst) begin
            m_reset();
            return;
        end
        acc = mtc0_we && !ex_valid && !eret;
`ifdef CP0_TIMER_EN
        hit = m_just && (m_count == m_cmp);
        if (acc && mtc0_addr == 5'd11) begin
            m_cmp = mtc0_wdata;
            m_ti  = 0;
        end else if (hit) begin
            m_ti = 1;
        end
        if (acc && mtc0_addr == 5'd9) begin
            m_count = mtc0_wdata; m_div = 0; m_just = 0;
        end else if (m_div == COUNT_DIV - 1) begin
            m_count = m_count + 1; m_div = 0; m_just = 1;
        end else begin
            m_div = m_div + 1; m_just = 0;
        end
`else
        hit = 0;
`endif
        m_hw = hw_int;
        if (ex_valid) begin
            if (!m_exl) begin
                m_epc = ex_bd ? ex_pc - 32'd4 : ex_pc;
                m_bd  = ex_bd;
            end
            m_exl  = 1;
            m_code = ex_code;
            if (ex_code == 5'd4 || ex_code == 5'd5) m_bad = ex_badvaddr;
        end else if (eret) begin
            m_exl = 0;
        end else if (mtc0_we) begin
            case (mtc0_addr)
                5'd12: begin m_im = mtc0_wdata[15:8]; m_exl = mtc0_wdata[1]; m_ie = mtc0_wdata[0]; end
                5'd13: m_sw = mtc0_wdata[9:8];
                5'd14: m_epc = mtc0_wdata;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        mfc0_addr = a;
        #1;
        chk(tag, mfc0_rdata, exp);
    endtask

    // Check combinational outputs against the model, then take one edge.
    task automatic tick();
        #1;
        chk("flush", 32'(flush), 32'(ex_valid | eret));
        chk("new_pc", new_pc, ex_valid ? EXC_VEC : m_epc);
        chk("int_req", 32'(int_req), 32'(m_irq()));
        chk("status_exl", 32'(status_exl), 32'(m_exl));
        chk("mfc0", mfc0_rdata, m_rd(mfc0_addr));
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0;
        ex_valid = 0; ex_code = 0; ex_bd = 0; ex_pc = 0; ex_badvaddr = 0; eret = 0;
    endtask

    task automatic sweep();
        logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
        for (int i = 0; i < 8; i++) rd_chk("sweep", addrs[i], m_rd(addrs[i]));
    endtask

    initial begin
        logic [4:0] pick [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        logic [4:0] codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        logic [31:0] old_epc;

        idle();
        hw_int = 0;
        mfc0_addr = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 0;

        // Reset state
        rd_chk("rst_status", 5'd12, 32'h0040_0000);
        rd_chk("rst_cause", 5'd13, 32'h0);
        rd_chk("rst_epc", 5'd14, 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_int_req", 32'(int_req), 32'h0);
        sweep();

        // Exception in a delay slot
        ex_valid = 1; ex_code = 5'd12; ex_bd = 1; ex_pc = 32'hBFC0_0104;
        #1;
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_new_pc", new_pc, 32'hBFC0_0380);
        tick();
        idle();
        rd_chk("exc_epc", 5'd14, 32'hBFC0_0100);
        rd_chk("exc_cause", 5'd13, 32'h8000_0030);
        chk("exc_exl", 32'(status_exl), 32'h1);

        // Nested exception keeps EPC and BD, updates ExcCode
        ex_valid = 1; ex_code = 5'd8; ex_bd = 0; ex_pc = 32'h1234;
        tick();
        idle();
        rd_chk("nest_epc", 5'd14, 32'hBFC0_0100);
        rd_chk("nest_cause", 5'd13, 32'h8000_0020);

        // ERET returns to the saved EPC
        eret = 1;
        #1;
        chk("eret_new_pc", new_pc, 32'hBFC0_0100);
        chk("eret_flush", 32'(flush), 32'h1);
        tick();
        idle();
        chk("eret_exl", 32'(status_exl), 32'h0);

        // Exception beats a same-cycle MTC0 to EPC
        ex_valid = 1; ex_code = 5'd4; ex_badvaddr = 32'h3; ex_pc = 32'h100;
        mtc0_we = 1; mtc0_addr = 5'd14; mtc0_wdata = 32'hDEAD_BEEF;
        tick();
        idle();
        rd_chk("prio_badvaddr", 5'd8, 32'h3);
        rd_chk("prio_epc", 5'd14, 32'h100);
        eret = 1;
        tick();
        idle();

        // Hardware interrupt line 0 with IM[2] and IE
        mtc0_we = 1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0000_0401;
        tick();
        idle();
        hw_int = 6'h01;
        #1;
        chk("hw_pre", 32'(int_req), 32'h0);
        tick();
        chk("hw_irq", 32'(int_req), 32'h1);
        rst = 1;
        tick();
        idle();
        chk("rst_irq", 32'(int_req), 32'h0);
        hw_int = 0;
        sweep();

`ifdef CP0_TIMER_EN
        mtc0_we = 1; mtc0_addr = 5'd11; mtc0_wdata = 32'd5;
        tick();
        mtc0_addr = 5'd12; mtc0_wdata = 32'h0000_8001;
        tick();
        idle();
        for (int i = 0; i < 40 && !int_req; i++) tick();
        chk("timer_irq", 32'(int_req), 32'h1);
        rd_chk("timer_ti", 5'd13, m_rd(5'd13) | 32'h4000_8000);
        mtc0_we = 1; mtc0_addr = 5'd11; mtc0_wdata = 32'd100;
        tick();
        idle();
        chk("timer_clr", 32'(int_req), 32'h0);
`else
        mtc0_we = 1; mtc0_addr = 5'd9; mtc0_wdata = 32'h55;
        tick();
        mtc0_addr = 5'd11; mtc0_wdata = 32'h66;
        tick();
        idle();
        rd_chk("no_count", 5'd9, 32'h0);
        rd_chk("no_compare", 5'd11, 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst         = ($urandom_range(0, 99) == 0);
            ex_valid    = ($urandom_range(0, 7) == 0);
            eret        = ($urandom_range(0, 7) == 0);
            mtc0_we     = ($urandom_range(0, 1) == 1);
            mtc0_addr   = pick[$urandom_range(0, 6)];
            mtc0_wdata  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            ex_code     = codes[$urandom_range(0, 6)];
            ex_bd       = 1'($urandom_range(0, 1));
            ex_pc       = $urandom;
            ex_badvaddr = $urandom;
            if ($urandom_range(0, 9) == 0) hw_int = 6'($urandom_range(0, 31));
            mfc0_addr   = pick[$urandom_range(0, 6)];
            tick();
            if (n % 500 == 0) begin
                idle();
                sweep();
            end
        end
        idle();
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
